// File: rtl/instr_encoder.sv
// RV32I instruction encoder and imem loader: packs decoded descriptors into
// 32-bit machine words, buffers them in a small FIFO and writes them to
// consecutive word addresses of the instruction memory.
module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_fmt,
  input  logic [2:0]        i_fun3,
  input  logic              i_alt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  input  logic              i_last,
  output logic              o_wr_en,
  input  logic              i_wr_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_done,
  output logic              o_err,
  output logic [7:0]        o_err_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       enc_word;
  logic              illegal;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              fifo_empty, fifo_full;
  logic              accept, push, pop, start_go;
  logic [ADDR_W-1:0] addr_q;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign accept     = i_valid && o_ready;
  assign push       = accept && !illegal;
  assign pop        = o_wr_en && i_wr_ready;
  assign start_go   = (state_q == IDLE) && i_start;

  assign o_wr_en   = !fifo_empty;
  assign o_wr_data = fifo_empty ? '0 : mem[rd_ptr];
  assign o_wr_addr = addr_q;

  // Field packing and legality check for the presented descriptor
  always_comb begin
    enc_word = '0;
    illegal  = 1'b0;
    case (i_fmt)
      4'd0: begin
        enc_word = {1'b0, i_alt, 5'b00000, i_rs2, i_rs1, i_fun3, i_rd, OP_R};
        illegal  = i_alt && !(i_fun3 == 3'b000 || i_fun3 == 3'b101);
      end
      4'd1: begin
        // shift-immediates carry the bit-30 selector above a 5-bit shamt
        if (i_fun3 == 3'b001 || i_fun3 == 3'b101)
          enc_word = {1'b0, i_alt, 5'b00000, i_imm[4:0], i_rs1, i_fun3, i_rd, OP_OPIMM};
        else
          enc_word = {i_imm[11:0], i_rs1, i_fun3, i_rd, OP_OPIMM};
        illegal = i_alt && (i_fun3 != 3'b101);
      end
      4'd2: begin
        enc_word = {i_imm[11:0], i_rs1, i_fun3, i_rd, OP_LOAD};
        illegal  = (i_fun3 == 3'b011) || (i_fun3 == 3'b110) || (i_fun3 == 3'b111);
      end
      4'd3: begin
        enc_word = {i_imm[11:5], i_rs2, i_rs1, i_fun3, i_imm[4:0], OP_STORE};
        illegal  = (i_fun3 > 3'b010);
      end
      4'd4: begin
        enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_fun3, i_imm[4:1], i_imm[11], OP_BRANCH};
        illegal  = (i_fun3 == 3'b010) || (i_fun3 == 3'b011);
      end
      4'd5: enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
      4'd6: begin
        enc_word = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
        illegal  = (i_fun3 != 3'b000);
      end
      4'd7: enc_word = {i_imm[31:12], i_rd, OP_LUI};
      4'd8: enc_word = {i_imm[31:12], i_rd, OP_AUIPC};
      default: illegal = 1'b1;
    endcase
  end

  // Session state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state, handshake ready and completion pulse
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      IDLE: if (i_start) state_d = RUN;
      RUN: begin
        o_ready = !fifo_full;
        if (accept && i_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
          o_done  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care while empty, so no reset
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Write address: loaded at session start, advances one word per write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      addr_q <= '0;
    else if (start_go) addr_q <= i_base_addr;
    else if (pop)      addr_q <= addr_q + ADDR_W'(4);
  end

  // Sticky error flag and saturating drop counter, cleared per session
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else if (start_go) begin
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else if (accept && illegal) begin
      o_err <= 1'b1;
      if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed sessions plus randomized
// descriptors compared against an arithmetic encoding model and write scoreboard.
module tb_instr_encoder;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_base_addr = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_fmt = '0;
  logic [2:0]  i_fun3 = '0;
  logic        i_alt = 1'b0;
  logic [4:0]  i_rd = '0, i_rs1 = '0, i_rs2 = '0;
  logic [31:0] i_imm = '0;
  logic        i_last = 1'b0;
  logic        o_wr_en;
  logic        i_wr_ready = 1'b0;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_done;
  logic        o_err;
  logic [7:0]  o_err_cnt;

  instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_valid(i_valid), .o_ready(o_ready), .i_fmt(i_fmt), .i_fun3(i_fun3), .i_alt(i_alt),
    .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_last(i_last),
    .o_wr_en(o_wr_en), .i_wr_ready(i_wr_ready), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_done(o_done), .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] model_addr = '0;
  int          err_model = 0;
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  int          wr_mode = 0;   // 0: imem stalls, 1: always ready, 2: random

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned fld(input int unsigned v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic bit ref_legal(input int unsigned fmt, f3, alt);
    case (fmt)
      0: return !(alt == 1 && !(f3 == 0 || f3 == 5));
      1: return !(alt == 1 && f3 != 5);
      2: return !(f3 == 3 || f3 == 6 || f3 == 7);
      3: return f3 <= 2;
      4: return !(f3 == 2 || f3 == 3);
      5, 7, 8: return 1'b1;
      6: return f3 == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned fmt, f3, alt, rd, rs1, rs2,
                                           input logic [31:0] imm);
    int unsigned ops[9] = '{51, 19, 3, 35, 99, 111, 103, 55, 23};
    int unsigned ui = imm;
    int unsigned op = ops[fmt];
    int unsigned w;
    case (fmt)
      0: w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (alt << 30);
      1: if (f3 == 1 || f3 == 5)
           w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (fld(ui, 4, 0) << 20) + (alt << 30);
         else
           w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (fld(ui, 11, 0) << 20);
      2, 6: w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (fld(ui, 11, 0) << 20);
      3: w = op + (fld(ui, 4, 0) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (fld(ui, 11, 5) << 25);
      4: w = op + (fld(ui, 11, 11) << 7) + (fld(ui, 4, 1) << 8) + (f3 << 12) + (rs1 << 15)
             + (rs2 << 20) + (fld(ui, 10, 5) << 25) + (fld(ui, 12, 12) << 31);
      5: w = op + (rd << 7) + (fld(ui, 19, 12) << 12) + (fld(ui, 11, 11) << 20)
             + (fld(ui, 10, 1) << 21) + (fld(ui, 20, 20) << 31);
      default: w = op + (rd << 7) + (ui & 32'hFFFF_F000);
    endcase
    return w;
  endfunction

  // imem ready driver, updated mid-cycle so the stimulus block can switch mode
  always @(posedge i_clk) begin
    #2;
    if (wr_mode == 0)      i_wr_ready = 1'b0;
    else if (wr_mode == 1) i_wr_ready = 1'b1;
    else                   i_wr_ready = 1'($urandom % 2);
  end

  // Write-port scoreboard and done-pulse counter
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_done) done_cnt++;
      if (o_wr_en && i_wr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {o_wr_addr, o_wr_data}, 64'd0);
        end else begin
          check("wr_addr", {32'd0, o_wr_addr}, {32'd0, exp_q[0].addr});
          check("wr_data", {32'd0, o_wr_data}, {32'd0, exp_q[0].data});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic start_session(input logic [31:0] base);
    check("ready_idle", {63'd0, o_ready}, 64'd0);
    i_start = 1'b1;
    i_base_addr = base;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    model_addr = base;
    err_model = 0;
    done_base = done_cnt;
    check("ready_after_start", {63'd0, o_ready}, 64'd1);
    check("err_cleared", {55'd0, o_err, o_err_cnt}, 64'd0);
  endtask

  task automatic send(input int unsigned fmt, f3, alt, rd, rs1, rs2, input logic [31:0] imm,
                      input bit last, input bit use_c, input logic [31:0] cword);
    bit got = 1'b0;
    i_valid = 1'b1; i_fmt = 4'(fmt); i_fun3 = 3'(f3); i_alt = 1'(alt);
    i_rd = 5'(rd); i_rs1 = 5'(rs1); i_rs2 = 5'(rs2); i_imm = imm; i_last = last;
    for (int n = 0; n < 300; n++) begin
      @(negedge i_clk);
      if (o_ready) begin got = 1'b1; break; end
    end
    if (!got) check("handshake_timeout", 64'd0, 64'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_last = 1'b0;
    if (got) begin
      if (ref_legal(fmt, f3, alt)) begin
        exp_q.push_back('{addr: model_addr,
                          data: use_c ? cword : ref_word(fmt, f3, alt, rd, rs1, rs2, imm)});
        model_addr = model_addr + 32'd4;
      end else begin
        err_model++;
      end
    end
  endtask

  task automatic end_session(input string tag);
    bit got = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge i_clk);
      if (done_cnt != done_base) begin got = 1'b1; break; end
    end
    if (!got) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    repeat (3) @(negedge i_clk);
    check({tag, "_done_once"}, 64'(done_cnt - done_base), 64'd1);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_err"}, {63'd0, o_err}, {63'd0, err_model != 0});
    check({tag, "_err_cnt"}, {56'd0, o_err_cnt}, 64'(err_model > 255 ? 255 : err_model));
    @(posedge i_clk); #1;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_addr, held_data;
    #12;
    check("rst_ready", {63'd0, o_ready}, 64'd0);
    check("rst_wr_en", {63'd0, o_wr_en}, 64'd0);
    check("rst_wr_addr", {32'd0, o_wr_addr}, 64'd0);
    check("rst_wr_data", {32'd0, o_wr_data}, 64'd0);
    check("rst_done_err", {54'd0, o_done, o_err, o_err_cnt}, 64'd0);
    i_rst_n = 1'b1;
    wr_mode = 1;
    @(posedge i_clk); #1;

    // ADDI then SUB
    start_session(32'h100);
    send(1, 0, 0, 1, 0, 0, 32'd5, 0, 1, 32'h0050_0093);
    send(0, 0, 1, 3, 1, 2, 32'd0, 1, 1, 32'h4020_81B3);
    end_session("s1");

    // SW, BEQ, JAL
    start_session(32'h200);
    send(3, 2, 0, 0, 1, 2, 32'd8, 0, 1, 32'h0020_A423);
    send(4, 0, 0, 0, 1, 2, 32'hFFFF_FFFC, 0, 1, 32'hFE20_8EE3);
    send(5, 0, 0, 1, 0, 0, 32'd8, 1, 1, 32'h0080_00EF);
    end_session("s2");

    // backpressure: FIFO fills after four, head holds while stalled
    wr_mode = 0;
    start_session(32'h300);
    for (int k = 0; k < 4; k++) send(1, 0, 0, k + 1, k, 0, 32'(k * 3), 0, 0, '0);
    @(negedge i_clk);
    check("bp_ready_low", {63'd0, o_ready}, 64'd0);
    check("bp_wr_en", {63'd0, o_wr_en}, 64'd1);
    check("bp_head_addr", {32'd0, o_wr_addr}, 64'h300);
    check("bp_head_data", {32'd0, o_wr_data}, {32'd0, exp_q[0].data});
    held_addr = o_wr_addr;
    held_data = o_wr_data;
    repeat (3) begin
      @(negedge i_clk);
      check("bp_hold", {o_wr_addr, o_wr_data}, {held_addr, held_data});
    end
    @(posedge i_clk); #1;
    wr_mode = 1;
    send(1, 0, 0, 9, 9, 0, 32'd77, 1, 0, '0);
    end_session("bp");

    // illegal descriptors dropped
    start_session(32'h400);
    send(12, 0, 0, 1, 1, 1, 32'd0, 0, 0, '0);
    send(3, 3, 0, 0, 1, 2, 32'd4, 0, 0, '0);
    send(1, 0, 0, 5, 0, 0, 32'd1, 1, 0, '0);
    end_session("illegal");

    // i_start during RUN is ignored
    start_session(32'h500);
    send(7, 0, 0, 4, 0, 0, 32'h1234_5000, 0, 0, '0);
    i_start = 1'b1; i_base_addr = 32'h900;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    send(8, 0, 0, 6, 0, 0, 32'hABCD_E000, 1, 0, '0);
    end_session("restart_ignored");

    // reset with words queued
    wr_mode = 0;
    start_session(32'h600);
    send(1, 0, 0, 1, 0, 0, 32'd1, 0, 0, '0);
    send(1, 0, 0, 2, 0, 0, 32'd2, 0, 0, '0);
    check("pre_rst_wr_en", {63'd0, o_wr_en}, 64'd1);
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", {63'd0, o_wr_en}, 64'd0);
    check("rst_mid_ready", {63'd0, o_ready}, 64'd0);
    exp_q.delete();
    done_base = done_cnt;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    wr_mode = 1;
    repeat (8) @(negedge i_clk);
    check("rst_no_done", 64'(done_cnt - done_base), 64'd0);
    check("rst_no_write", {63'd0, o_wr_en}, 64'd0);
    check("rst_idle", {63'd0, o_ready}, 64'd0);
    @(posedge i_clk); #1;

    // address wrap
    start_session(32'hFFFF_FFFC);
    send(2, 2, 0, 3, 4, 0, 32'hFFFF_FFF0, 0, 0, '0);
    send(6, 0, 0, 1, 5, 0, 32'd16, 1, 0, '0);
    end_session("wrap");

    // all-illegal session: done in the cycle after the last acceptance
    start_session(32'h700);
    send(6, 1, 0, 1, 1, 0, 32'd0, 1, 0, '0);
    @(negedge i_clk);
    check("all_illegal_done", {63'd0, o_done}, 64'd1);
    end_session("all_illegal");

    // error counter saturation
    start_session(32'h800);
    for (int k = 0; k < 260; k++) send(15, 0, 0, 0, 0, 0, '0, k == 259, 0, '0);
    end_session("sat");

    // randomized sessions with random imem backpressure
    wr_mode = 2;
    for (int s = 0; s < 4; s++) begin
      start_session($urandom & 32'hFFFF_FFFC);
      for (int k = 0; k < 40; k++) begin
        int unsigned fmt = ($urandom % 4 == 0) ? $urandom_range(15, 9) : $urandom_range(8, 0);
        send(fmt, $urandom % 8, ($urandom % 4 == 0) ? 1 : 0, $urandom % 32, $urandom % 32,
             $urandom % 32, $urandom, k == 39, 0, '0);
        repeat ($urandom % 3) begin @(posedge i_clk); #1; end
      end
      end_session("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
